// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the cacheline memory arbiter: FSM encoding, arbitration
// mode selectors, default address/line types and an index-width helper.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef logic [31:0]  addr_t;
    typedef logic [255:0] line_t;

    // Width of a binary client index; at least one bit even for one client.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: the first set request at or after
// `base`, wrapping around, wins. A base of zero gives fixed lowest-index
// priority.
module rr_priority_picker
    import arbiter_types::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       base,
    output logic [NUM_CLIENTS-1:0] grant_oh,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   valid
);

    int   cand;
    logic found;

    // Scan clients starting at base; the first requester takes the grant.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            cand = int'(base) + k;
            if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant_oh[cand]  = 1'b1;
                grant_idx       = IDX_W'(cand);
            end
        end
        valid = found;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-client cacheline arbiter in front of the single physical-memory adaptor.
// The winning request is captured at grant time so the adaptor sees stable
// address/data/op for the whole transaction.
//
// Handshake: clients hold client_read/client_write high (level) until they
// see their one-cycle client_resp pulse; the adaptor sees pmem_read/pmem_write
// held high until it returns pmem_resp for one cycle, which completes the
// transaction in that same cycle.
module mem_arbiter_rr
    import arbiter_types::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int ARB_MODE    = ARB_RR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] client_wdata,
    input  logic [NUM_CLIENTS-1:0]            client_read,
    input  logic [NUM_CLIENTS-1:0]            client_write,
    output logic [LINE_WIDTH-1:0]             client_rdata,
    output logic [NUM_CLIENTS-1:0]            client_resp,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]             pmem_address,
    output logic [LINE_WIDTH-1:0]             pmem_wdata,
    output logic                              pmem_read,
    output logic                              pmem_write,
    input  logic [LINE_WIDTH-1:0]             pmem_rdata,
    input  logic                              pmem_resp,
    output logic [1:0]                        state_dbg
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);

    arb_state_t             state, next_state;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       pick_base;
    logic                   arbitrate;

    logic [NUM_CLIENTS-1:0] grant_q;
    logic                   op_write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LINE_WIDTH-1:0]  sel_wdata;
    logic                   sel_write;

    assign req       = client_read | client_write;
    assign pick_base = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;
    assign arbitrate = (state != BUSY) && win_valid;

    rr_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req       (req),
        .base      (pick_base),
        .grant_oh  (win_oh),
        .grant_idx (win_idx),
        .valid     (win_valid)
    );

    // Route the winning client's address, data and op to the capture registers.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_oh[i]) begin
                sel_addr  = client_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = client_wdata[i*LINE_WIDTH +: LINE_WIDTH];
                sel_write = client_write[i];
            end
        end
    end

    // Next-state: IDLE and DONE both arbitrate; BUSY waits for the adaptor.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = win_valid ? BUSY : IDLE;
            BUSY:       next_state = pmem_resp ? DONE : BUSY;
            default:    next_state = IDLE;
        endcase
    end

    // State, request capture, grant ownership and rotating pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= next_state;
            if (arbitrate) begin
                grant_q    <= win_oh;
                op_write_q <= sel_write;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                if (win_idx == IDX_W'(NUM_CLIENTS - 1)) rr_ptr <= '0;
                else                                    rr_ptr <= win_idx + 1'b1;
            end else if (state == BUSY && pmem_resp) begin
                grant_q <= '0;
            end
        end
    end

    // Flag a client that asks for read and write at once; the write is served.
    always_ff @(posedge clk) begin
        if (!rst && arbitrate && sel_write) begin
            assert ((client_read & win_oh) == '0)
            else $warning("mem_arbiter_rr: client %0d read and write both high, serving write", win_idx);
        end
    end

    assign grant        = (state == BUSY) ? grant_q : '0;
    assign pmem_read    = (state == BUSY) && !op_write_q;
    assign pmem_write   = (state == BUSY) &&  op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign client_rdata = pmem_rdata;
    assign client_resp  = (state == BUSY && pmem_resp) ? grant_q : '0;
    assign state_dbg    = state;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: a 3-client round-robin arbiter for most scenarios and a
// 2-client fixed-priority arbiter for the priority-starvation scenario.
module tb_mem_arbiter_rr;

    localparam int AW = 32;
    localparam int LW = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- round-robin instance (3 clients) ----------------
    logic [3*AW-1:0] c_addr;
    logic [3*LW-1:0] c_wdata;
    logic [2:0]      c_read, c_write, c_resp, c_grant;
    logic [LW-1:0]   c_rdata, p_wdata, p_rdata;
    logic [AW-1:0]   p_addr;
    logic            p_read, p_write, p_resp;
    logic [1:0]      c_state;

    mem_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .client_address(c_addr), .client_wdata(c_wdata),
        .client_read(c_read), .client_write(c_write),
        .client_rdata(c_rdata), .client_resp(c_resp), .grant(c_grant),
        .pmem_address(p_addr), .pmem_wdata(p_wdata),
        .pmem_read(p_read), .pmem_write(p_write),
        .pmem_rdata(p_rdata), .pmem_resp(p_resp),
        .state_dbg(c_state)
    );

    // ---------------- fixed-priority instance (2 clients) ----------------
    logic [2*AW-1:0] f_addr;
    logic [2*LW-1:0] f_wdata;
    logic [1:0]      f_read, f_write, f_resp, f_grant;
    logic [LW-1:0]   f_rdata, fp_wdata, fp_rdata;
    logic [AW-1:0]   fp_addr;
    logic            fp_read, fp_write, fp_resp;
    logic [1:0]      f_state;

    mem_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst(rst),
        .client_address(f_addr), .client_wdata(f_wdata),
        .client_read(f_read), .client_write(f_write),
        .client_rdata(f_rdata), .client_resp(f_resp), .grant(f_grant),
        .pmem_address(fp_addr), .pmem_wdata(fp_wdata),
        .pmem_read(fp_read), .pmem_write(fp_write),
        .pmem_rdata(fp_rdata), .pmem_resp(fp_resp),
        .state_dbg(f_state)
    );

    // ---------------- scoreboard ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [2:0] exp_q[$];

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_dead;
    logic [LW-1:0] line_beef;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        line_a5   = {32{8'hA5}};
        line_dead = {8{32'hDEADBEEF}};
        line_beef = {8{32'h0BEEF000}};

        rst = 1'b1;
        c_addr = '0; c_wdata = '0; c_read = '0; c_write = '0;
        p_rdata = '0; p_resp = 1'b0;
        f_addr = '0; f_wdata = '0; f_read = '0; f_write = '0;
        fp_rdata = '0; fp_resp = 1'b0;

        // Reset values
        tick(); tick();
        sample();
        check("rst_state",  LW'(c_state), LW'(2'd0));
        check("rst_grant",  LW'(c_grant), '0);
        check("rst_pread",  LW'(p_read),  '0);
        check("rst_pwrite", LW'(p_write), '0);
        check("rst_paddr",  LW'(p_addr),  '0);
        check("rst_pwdata", p_wdata,      '0);
        check("rst_resp",   LW'(c_resp),  '0);

        // 1: client0 read at 0x1040, adaptor answers in the 5th busy cycle
        tick();
        rst = 1'b0;
        c_addr[0 +: AW] = 32'h0000_1040;
        c_read[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) begin
                p_resp  = 1'b1;
                p_rdata = line_a5;
            end
            sample();
            check("t1_pread", LW'(p_read), LW'(1'b1));
            check("t1_paddr", LW'(p_addr), LW'(32'h0000_1040));
            if (c == 5) begin
                check("t1_resp",  LW'(c_resp), LW'(3'b001));
                check("t1_rdata", c_rdata,     line_a5);
            end else begin
                check("t1_noresp", LW'(c_resp), '0);
            end
        end
        tick();
        p_resp = 1'b0;
        c_read[0] = 1'b0;
        sample();
        check("t1_done_grant", LW'(c_grant), '0);
        check("t1_done_pread", LW'(p_read),  '0);
        check("t1_done_resp",  LW'(c_resp),  '0);
        check("t1_done_state", LW'(c_state), LW'(2'd2));
        tick();

        // 2: reset pointer, three clients read continuously, latency 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_read = 3'b111;
        p_resp = 1'b1;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] exp_g;
            exp_g = exp_q.pop_front();
            tick();
            sample();
            check("t2_grant", LW'(c_grant), LW'(exp_g));
            check("t2_resp",  LW'(c_resp),  LW'(exp_g));
            tick();
            if (i == 3) begin
                c_read = '0;
                p_resp = 1'b0;
            end
            sample();
            check("t2_done_grant", LW'(c_grant), '0);
            check("t2_done_resp",  LW'(c_resp),  '0);
        end
        tick();

        // 4: client1 write; inputs change mid-transaction but pmem side holds
        c_addr[AW +: AW]  = 32'h0000_2000;
        c_wdata[LW +: LW] = line_dead;
        c_write[1] = 1'b1;
        tick();
        sample();
        check("t4_grant",  LW'(c_grant), LW'(3'b010));
        check("t4_pwrite", LW'(p_write), LW'(1'b1));
        check("t4_pread",  LW'(p_read),  '0);
        tick();
        c_addr[AW +: AW]  = 32'hFFFF_FFE0;
        c_wdata[LW +: LW] = line_beef;
        sample();
        check("t4_paddr_hold",  LW'(p_addr), LW'(32'h0000_2000));
        check("t4_pwdata_hold", p_wdata,     line_dead);
        tick();
        p_resp = 1'b1;
        sample();
        check("t4_paddr_resp", LW'(p_addr), LW'(32'h0000_2000));
        check("t4_pwdata_resp", p_wdata,    line_dead);
        check("t4_resp",       LW'(c_resp), LW'(3'b010));
        tick();
        p_resp = 1'b0;
        c_write[1] = 1'b0;
        sample();
        check("t4_done_pwrite", LW'(p_write), '0);
        tick();

        // 5: reset in the 3rd busy cycle of a client0 read (pointer left at 1)
        c_addr[0 +: AW] = 32'h0000_3000;
        c_read[0] = 1'b1;
        tick();
        sample();
        check("t5_grant", LW'(c_grant), LW'(3'b001));
        tick();
        tick();
        rst = 1'b1;
        c_read[1] = 1'b1;
        sample();
        check("t5_busy3_state", LW'(c_state), LW'(2'd1));
        tick();
        rst = 1'b0;
        sample();
        check("t5_rst_pread", LW'(p_read),  '0);
        check("t5_rst_grant", LW'(c_grant), '0);
        check("t5_rst_resp",  LW'(c_resp),  '0);
        check("t5_rst_state", LW'(c_state), LW'(2'd0));
        tick();
        p_resp = 1'b1;
        sample();
        check("t5_regrant", LW'(c_grant), LW'(3'b001));
        check("t5_resp",    LW'(c_resp),  LW'(3'b001));
        tick();
        c_read = '0;
        p_resp = 1'b0;
        tick();

        // 6: client0 read and write both high -> served as a write
        c_addr[0 +: AW]  = 32'h0000_4000;
        c_wdata[0 +: LW] = line_beef;
        c_read[0]  = 1'b1;
        c_write[0] = 1'b1;
        tick();
        p_resp = 1'b1;
        sample();
        check("t6_pwrite", LW'(p_write), LW'(1'b1));
        check("t6_pread",  LW'(p_read),  '0);
        check("t6_paddr",  LW'(p_addr),  LW'(32'h0000_4000));
        check("t6_resp",   LW'(c_resp),  LW'(3'b001));
        tick();
        c_read = '0;
        c_write = '0;
        p_resp = 1'b0;
        tick();

        // 3: fixed priority, clients 0 and 1 request continuously
        f_read = 2'b11;
        fp_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("t3_grant", LW'(f_grant), LW'(2'b01));
            check("t3_resp",  LW'(f_resp),  LW'(2'b01));
            tick();
            sample();
            check("t3_done_grant", LW'(f_grant), '0);
        end
        f_read = '0;
        fp_resp = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised N-client arbiter that serialises cacheline read/write requests from NUM_CLIENTS caches (I-cache, D-cache, future prefetch/victim buffers) onto the single physical-memory adaptor port. It is the successor to the two-client fixed arbiter. It adds round-robin or fixed-priority selection, latched request capture so pmem-side signals stay stable for the whole transaction, and per-client one-hot grant visibility.

Parameters:
NUM_CLIENTS, 2, number of requesting caches (2..8)
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cacheline width in bits
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
client_address  input  NUM_CLIENTS x ADDR_WIDTH  per-client line address
client_wdata  input  NUM_CLIENTS x LINE_WIDTH  per-client write line
client_read  input  NUM_CLIENTS  per-client read request (level, held until resp)
client_write  input  NUM_CLIENTS  per-client write request (level, held until resp)
client_rdata  output  LINE_WIDTH  read line broadcast to all clients
client_resp  output  NUM_CLIENTS  one-hot, 1-cycle completion pulse
grant  output  NUM_CLIENTS  one-hot owner of current transaction, 0 when idle
pmem_address  output  ADDR_WIDTH  latched address to adaptor
pmem_wdata  output  LINE_WIDTH  latched write line to adaptor
pmem_read  output  1  read strobe to adaptor
pmem_write  output  1  write strobe to adaptor
pmem_rdata  input  LINE_WIDTH  read line from adaptor
pmem_resp  input  1  adaptor completion

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, grant=0, pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, client_resp=0, rr pointer=0 (client 0 highest priority).
- States:
  - IDLE: no transaction outstanding.
  - BUSY: transaction issued to pmem.
  - DONE: one-cycle retire.
- Request vector: req[i] = client_read[i] | client_write[i].
- Arbitration happens in IDLE and DONE.
  - If any req[i] is set, the picker selects a winner.
  - At the clock edge: latch address, wdata and op (write if client_write, else read) into internal registers; set grant one-hot; go to BUSY.
  - If no request: go to or stay in IDLE.
- Picker:
  - ARB_MODE=0: first set req at or after index (rr_ptr), wrapping modulo NUM_CLIENTS. rr_ptr <= winner+1 (mod NUM_CLIENTS) on entry to BUSY.
  - ARB_MODE=1: lowest set index; rr_ptr unused.
- BUSY:
  - pmem_read/pmem_write driven from the latched op; pmem_address and pmem_wdata come from the latches. Client input changes are ignored.
  - On pmem_resp=1: client_resp[winner]=1 combinationally in the same cycle; client_rdata=pmem_rdata; next state DONE.
  - pmem_read/pmem_write drop at that edge.
- DONE: grant=0, pmem strobes 0, client_resp=0. Arbitrates as IDLE.
  - The served client has seen resp, so a re-asserted request from it is a new transaction.
- Latency: request first visible in cycle t; pmem strobe asserted in cycle t+1; client_resp in the same cycle as pmem_resp; earliest next grant strobe is 2 cycles after resp.
- client_rdata equals pmem_rdata at all times (broadcast). It is only valid while client_resp is high.
- Client drops its request while in BUSY: the transaction still completes and resp still pulses.
- client_read and client_write both high on one client: treated as write; simulation assertion fires.
- pmem_resp while not in BUSY: ignored.
- rst asserted mid-transaction: return to IDLE next edge, strobes low, no resp pulse, rr_ptr=0. Any in-flight adaptor operation is abandoned.
- NUM_CLIENTS=1 degenerates to a registered pass-through with the same timing.

Decomposition:
- Package arbiter_types: enum arb_state_t {IDLE, BUSY, DONE}; localparams ARB_RR=0, ARB_FIXED=1.
- Existing addr_t and line_t from the shared types package are the defaults for the 32/256 widths.
- One sub-module: rr_priority_picker.
  - Purely combinational: inputs req and base index, output one-hot plus binary index.
  - Parametrised on NUM_CLIENTS; ARB_FIXED passes base=0.

Test Plan:
1. Reset, then client0 read at 0x0000_1040; pmem_resp after 5 cycles with rdata=0xA5.. -> pmem_read high for 5 cycles with address 0x0000_1040; client_resp=01 in the resp cycle; client_rdata=0xA5..; grant=0 the next cycle.
2. NUM_CLIENTS=3, RR mode, all three request reads continuously, pmem_resp latency 1 -> grant order 001, 010, 100, 001; each resp is a single-cycle pulse.
3. ARB_MODE=1, clients 0 and 1 request continuously -> client 1 never granted while client 0 re-requests; grant stays 01 every transaction.
4. Client1 write at 0x0000_2000, data 0xDEAD..; address changed to 0xFFFF_FFE0 in the 2nd BUSY cycle -> pmem_address stays 0x0000_2000 and pmem_wdata stays 0xDEAD.. until resp.
5. rst asserted in the 3rd BUSY cycle -> next cycle pmem_read=0, grant=0, no client_resp; after reset, client0 is granted first even if rr_ptr was 1.
6. Client0 read+write both high -> pmem_write asserted, pmem_read low, assertion logged; resp pulses to client0.
